// File: rtl/mmm_input_arbiter.sv
// rtl/mmm_input_arbiter.sv - whole-job two-source arbiter feeding one MMM engine, tags every result word with its owner
// Optional feature: define MMM_ARB_RR_EN for round-robin tie-break; otherwise S0 has fixed priority.
module mmm_input_arbiter #(
    parameter int  INW    = 12,
    parameter int  M      = 7,
    parameter int  N      = 9,
    parameter int  MAXK   = 8,
    parameter int  TAGQ   = 2,
    localparam int K_BITS = $clog2(MAXK + 1),
    localparam int UW     = K_BITS + 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,

    input  logic [INW-1:0] i_s0_tdata,
    input  logic           i_s0_tvalid,
    input  logic [UW-1:0]  i_s0_tuser,
    output logic           o_s0_tready,

    input  logic [INW-1:0] i_s1_tdata,
    input  logic           i_s1_tvalid,
    input  logic [UW-1:0]  i_s1_tuser,
    output logic           o_s1_tready,

    output logic [INW-1:0] o_m_tdata,
    output logic           o_m_tvalid,
    output logic [UW-1:0]  o_m_tuser,
    input  logic           i_m_tready,

    input  logic           i_res_tvalid,
    input  logic           i_res_tready,
    output logic           o_res_tid,
    output logic           o_res_tid_valid,

    output logic           o_busy,
    output logic           o_hdr_err
);

    localparam int CW = $clog2(M * MAXK + MAXK * N + 1);
    localparam int RW = $clog2(M * N + 1);
    localparam int QW = (TAGQ > 1) ? $clog2(TAGQ) : 1;
    localparam int NW = $clog2(TAGQ + 1);

    localparam logic [CW-1:0]     M_C      = CW'(M);
    localparam logic [CW-1:0]     N_C      = CW'(N);
    localparam logic [K_BITS-1:0] K_MAX    = K_BITS'(MAXK);
    localparam logic [RW-1:0]     RES_LAST = RW'(M * N - 1);
    localparam logic [NW-1:0]     TAGQ_N   = NW'(TAGQ);
    localparam logic [QW-1:0]     PTR_LAST = QW'(TAGQ - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;
    logic            w_owner_nxt;
    logic [CW-1:0]   r_beat_cnt;
    logic [CW-1:0]   w_beat_cnt_nxt;
    logic [CW-1:0]   r_job_len;
    logic [CW-1:0]   w_job_len_nxt;
    logic            r_hdr_err;
    logic            w_hdr_err_nxt;
    logic            w_push;

    logic [TAGQ-1:0] r_tag_mem;
    logic [QW-1:0]   r_wr_ptr;
    logic [QW-1:0]   r_rd_ptr;
    logic [NW-1:0]   r_tag_cnt;
    logic [RW-1:0]   r_res_cnt;

    logic            w_pass;
    logic            w_own_tvalid;
    logic [INW-1:0]  w_own_tdata;
    logic [UW-1:0]   w_own_tuser;
    logic [K_BITS-1:0] w_k;
    logic [CW-1:0]   w_k_ext;
    logic            w_a_only;
    logic            w_bad_hdr;
    logic [CW-1:0]   w_len_a;
    logic [CW-1:0]   w_len_b;
    logic [CW-1:0]   w_hdr_len;
    logic            w_first;
    logic [CW-1:0]   w_len_cur;
    logic            w_beat_hs;
    logic            w_last_beat;
    logic            w_any_req;
    logic            w_grant;
    logic            w_winner;
    logic            w_q_empty;
    logic            w_res_hs;
    logic            w_pop;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + QW'(1);
    endfunction

    // Owner-selected view of the requester streams
    assign w_own_tvalid = r_owner ? i_s1_tvalid : i_s0_tvalid;
    assign w_own_tdata  = r_owner ? i_s1_tdata  : i_s0_tdata;
    assign w_own_tuser  = r_owner ? i_s1_tuser  : i_s0_tuser;

    assign w_pass       = (r_state == ST_PASS);
    assign o_m_tvalid   = w_pass & w_own_tvalid;
    assign o_m_tdata    = w_pass ? w_own_tdata : '0;
    assign o_m_tuser    = w_pass ? w_own_tuser : '0;
    assign o_s0_tready  = w_pass & ~r_owner & i_m_tready;
    assign o_s1_tready  = w_pass &  r_owner & i_m_tready;
    assign o_busy       = w_pass;
    assign o_hdr_err    = r_hdr_err;

    // Job length decode; a bad K collapses the job to a single beat
    assign w_k       = w_own_tuser[K_BITS-1:0];
    assign w_a_only  = w_own_tuser[K_BITS];
    assign w_k_ext   = CW'(w_k);
    assign w_bad_hdr = (w_k == '0) || (w_k > K_MAX);
    assign w_len_a   = M_C * w_k_ext;
    assign w_len_b   = N_C * w_k_ext;
    assign w_hdr_len = w_bad_hdr ? CW'(1) : (w_a_only ? w_len_a : w_len_a + w_len_b);

    assign w_first     = (r_beat_cnt == '0);
    assign w_len_cur   = w_first ? w_hdr_len : r_job_len;
    assign w_beat_hs   = o_m_tvalid & i_m_tready;
    assign w_last_beat = w_beat_hs && ((r_beat_cnt + CW'(1)) == w_len_cur);

    assign w_any_req = i_s0_tvalid | i_s1_tvalid;
    assign w_grant   = (r_state == ST_IDLE) && w_any_req && (r_tag_cnt < TAGQ_N);

`ifdef MMM_ARB_RR_EN
    logic r_last_owner;

    always_comb begin
        w_winner = ~i_s0_tvalid;
        if (i_s0_tvalid && i_s1_tvalid) begin
            w_winner = ~r_last_owner;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_owner <= 1'b1;
        end else if (w_grant) begin
            r_last_owner <= w_winner;
        end
    end
`else
    always_comb begin
        w_winner = ~i_s0_tvalid;
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        w_job_len_nxt  = r_job_len;
        w_hdr_err_nxt  = 1'b0;
        w_push         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt    = ST_PASS;
                    w_owner_nxt    = w_winner;
                    w_beat_cnt_nxt = '0;
                    w_push         = 1'b1;
                end
            end
            ST_PASS: begin
                if (w_beat_hs) begin
                    if (w_first) begin
                        w_job_len_nxt = w_hdr_len;
                        w_hdr_err_nxt = w_bad_hdr;
                    end
                    if (w_last_beat) begin
                        w_state_nxt    = ST_IDLE;
                        w_beat_cnt_nxt = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_beat_cnt <= '0;
            r_job_len  <= '0;
            r_hdr_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_job_len  <= w_job_len_nxt;
            r_hdr_err  <= w_hdr_err_nxt;
        end
    end

    // Owner tag queue; a result handshake with nothing queued belongs to no job and is ignored
    assign w_q_empty = (r_tag_cnt == '0);
    assign w_res_hs  = i_res_tvalid & i_res_tready & ~w_q_empty;
    assign w_pop     = w_res_hs && (r_res_cnt == RES_LAST);

    assign o_res_tid_valid = ~w_q_empty;
    assign o_res_tid       = ~w_q_empty & r_tag_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_mem <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tag_cnt <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= w_winner;
                r_wr_ptr            <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + NW'(1);
                2'b01:   r_tag_cnt <= r_tag_cnt - NW'(1);
                default: r_tag_cnt <= r_tag_cnt;
            endcase
            if (w_res_hs) begin
                r_res_cnt <= w_pop ? '0 : r_res_cnt + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mmm_input_arbiter.sv
// tb/tb_mmm_input_arbiter.sv - randomized scoreboard bench for mmm_input_arbiter against a job-level reference model
`timescale 1ns/1ps
module tb_mmm_input_arbiter;

    localparam int INW  = 12;
    localparam int M    = 7;
    localparam int N    = 9;
    localparam int MAXK = 8;
    localparam int TAGQ = 2;
    localparam int KB   = $clog2(MAXK + 1);
    localparam int UW   = KB + 1;

    typedef logic [UW+INW-1:0] beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [INW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic           s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic [UW-1:0]  s0_tuser = '0, s1_tuser = '0;
    logic           s0_tready, s1_tready;
    logic [INW-1:0] m_tdata;
    logic           m_tvalid;
    logic [UW-1:0]  m_tuser;
    logic           m_tready = 1'b0;
    logic           res_tvalid = 1'b0, res_tready = 1'b0;
    logic           res_tid, res_tid_valid, busy, hdr_err;

    int n_checks = 0;
    int n_pass   = 0;
    int mrdy_pct = 100;
    int res_pct  = 100;
    bit res_hold = 1'b0;
    int gap_pct  = 0;

    beat_t exp0[$];
    beat_t exp1[$];

    // Reference model state: job in progress, its owner, beats left, owner tags awaiting results
    bit mp = 1'b0;
    bit mo = 1'b0;
    bit ml = 1'b1;
    int mbeats = 0;
    int mlen = 0;
    bit mtags[$];
    int mrc = 0;
    bit mhdr = 1'b0;

    mmm_input_arbiter #(.INW(INW), .M(M), .N(N), .MAXK(MAXK), .TAGQ(TAGQ)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s0_tdata(s0_tdata), .i_s0_tvalid(s0_tvalid), .i_s0_tuser(s0_tuser), .o_s0_tready(s0_tready),
        .i_s1_tdata(s1_tdata), .i_s1_tvalid(s1_tvalid), .i_s1_tuser(s1_tuser), .o_s1_tready(s1_tready),
        .o_m_tdata(m_tdata), .o_m_tvalid(m_tvalid), .o_m_tuser(m_tuser), .i_m_tready(m_tready),
        .i_res_tvalid(res_tvalid), .i_res_tready(res_tready),
        .o_res_tid(res_tid), .o_res_tid_valid(res_tid_valid),
        .o_busy(busy), .o_hdr_err(hdr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired before completion at %0t", name, $time);
    endtask

    function automatic bit bad_k(input int k);
        return (k == 0) || (k > MAXK);
    endfunction

    function automatic int job_len(input int k, input bit ao);
        if (bad_k(k)) return 1;
        return ao ? M * k : M * k + k * N;
    endfunction

    task automatic set_src(input int s, input bit v, input logic [INW-1:0] d, input logic [UW-1:0] u);
        if (s == 0) begin s0_tvalid = v; s0_tdata = d; s0_tuser = u; end
        else        begin s1_tvalid = v; s1_tdata = d; s1_tuser = u; end
    endtask

    task automatic send_job(input int s, input int k, input bit ao);
        int len;
        int wc;
        bit hs;
        logic [INW-1:0] d;
        logic [UW-1:0] u;
        len = job_len(k, ao);
        for (int b = 0; b < len; b++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                set_src(s, 1'b0, '0, '0);
                @(posedge clk); #1;
            end
            d = INW'($urandom);
            u = (b == 0) ? {ao, KB'(k)} : UW'($urandom);
            if (s == 0) exp0.push_back({u, d}); else exp1.push_back({u, d});
            set_src(s, 1'b1, d, u);
            wc = 0;
            do begin
                @(negedge clk);
                hs = (s == 0) ? (s0_tvalid && s0_tready) : (s1_tvalid && s1_tready);
                @(posedge clk); #1;
                wc++;
            end while (!hs && wc < 4000);
            if (!hs) begin
                fail_now("beat_handshake");
                set_src(s, 1'b0, '0, '0);
                return;
            end
        end
        set_src(s, 1'b0, '0, '0);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((mp || mtags.size() != 0) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= budget) fail_now("drain");
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            m_tready = ($urandom_range(0, 99) < mrdy_pct);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            res_tvalid = ($urandom_range(0, 99) < res_pct);
            res_tready = !res_hold && ($urandom_range(0, 99) < res_pct);
        end
    end

    // Monitor: compare outputs against the model, then advance the model with this cycle's inputs
    always @(negedge clk) begin : monitor
        bit ov, hs, nh, w;
        int sz0;
        logic [UW-1:0] ou;
        beat_t e;
        if (!rst_n) begin
            mp = 1'b0; ml = 1'b1; mbeats = 0; mrc = 0; mhdr = 1'b0;
            mtags.delete(); exp0.delete(); exp1.delete();
        end
        ov = mp ? (mo ? s1_tvalid : s0_tvalid) : 1'b0;
        chk("busy", busy, mp);
        chk("m_tvalid", m_tvalid, ov);
        chk("s0_tready", s0_tready, mp && !mo && m_tready);
        chk("s1_tready", s1_tready, mp && mo && m_tready);
        chk("res_tid_valid", res_tid_valid, mtags.size() != 0);
        chk("res_tid", res_tid, (mtags.size() != 0) ? mtags[0] : 1'b0);
        chk("hdr_err", hdr_err, mhdr);
        if (rst_n) begin
            nh = 1'b0;
            sz0 = mtags.size();
            if (!mp) begin
                if (sz0 < TAGQ && (s0_tvalid || s1_tvalid)) begin
`ifdef MMM_ARB_RR_EN
                    w = (s0_tvalid && s1_tvalid) ? !ml : !s0_tvalid;
                    ml = w;
`else
                    w = !s0_tvalid;
`endif
                    mo = w; mp = 1'b1; mbeats = 0;
                    mtags.push_back(w);
                end
            end else begin
                hs = ov && m_tready;
                if (hs) begin
                    ou = mo ? s1_tuser : s0_tuser;
                    if (mbeats == 0) begin
                        mlen = job_len(int'(ou[KB-1:0]), ou[KB]);
                        nh = bad_k(int'(ou[KB-1:0]));
                    end
                    if ((mo && exp1.size() == 0) || (!mo && exp0.size() == 0)) begin
                        fail_now("expected_beat_available");
                    end else begin
                        e = mo ? exp1.pop_front() : exp0.pop_front();
                        chk("m_beat", {m_tuser, m_tdata}, e);
                    end
                    mbeats++;
                    if (mbeats == mlen) mp = 1'b0;
                end
            end
            if (res_tvalid && res_tready && sz0 != 0) begin
                mrc++;
                if (mrc == M * N) begin
                    void'(mtags.pop_front());
                    mrc = 0;
                end
            end
            mhdr = nh;
        end
    end

    initial begin
        int nb;
        int wc;
        logic [UW-1:0] u;
        logic [INW-1:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single full job from S0 with everything ready
        send_job(0, 4, 1'b0);
        wait_drain(3000);

        // Both sources back-to-back A-only jobs
        fork
            begin repeat (4) send_job(0, 4, 1'b1); end
            begin repeat (4) send_job(1, 4, 1'b1); end
        join
        wait_drain(3000);

        // Random headers, gaps, backpressure and result traffic
        mrdy_pct = 70; gap_pct = 20; res_pct = 80;
        fork
            begin repeat (5) send_job(0, $urandom_range(0, 10), 1'($urandom_range(0, 1))); end
            begin repeat (5) send_job(1, $urandom_range(0, 10), 1'($urandom_range(0, 1))); end
        join
        mrdy_pct = 100; gap_pct = 0; res_pct = 100;
        wait_drain(3000);

        // Bad headers: each is a single-beat job
        send_job(0, 0, 1'b0);
        send_job(0, 9, 1'b0);
        send_job(1, 15, 1'b1);
        wait_drain(3000);

        // Results stalled: the third job waits for the tag queue
        res_hold = 1'b1;
        fork
            begin repeat (3) send_job(0, 1, 1'b1); end
            begin
                repeat (80) @(posedge clk);
                @(negedge clk);
                chk("qfull_busy", busy, 0);
                chk("qfull_tid_valid", res_tid_valid, 1);
                chk("qfull_s0_tready", s0_tready, 0);
                @(posedge clk); #1;
                res_hold = 1'b0;
            end
        join
        wait_drain(3000);

        // Reset in the middle of a 64-beat job
        u = {1'b0, KB'(4)};
        d = 12'h5A5;
        for (int b = 0; b < 64; b++) exp0.push_back({u, d});
        set_src(0, 1'b1, d, u);
        nb = 0; wc = 0;
        while (nb < 10 && wc < 500) begin
            @(negedge clk);
            if (s0_tvalid && s0_tready) nb++;
            wc++;
        end
        if (nb < 10) fail_now("reset_job_progress");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_tid_valid", res_tid_valid, 0);
        chk("rst_tid", res_tid, 0);
        chk("rst_hdr_err", hdr_err, 0);
        set_src(0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send_job(1, 4, 1'b0);
        wait_drain(3000);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("exp0_left", exp0.size(), 0);
        chk("exp1_left", exp1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmm_input_arbiter.md
# mmm_input_arbiter

- Shares one MMM engine between two independent AXI-Stream job sources.
- Arbitrates at whole-job granularity and forwards the granted source's beats unmodified to the MMM input port.
- Tracks job ownership so every result word leaving the MMM output FIFO carries a source ID.
- Sits between the two requester streams and MMM's INPUT_* port; snoops the MMM OUTPUT_* handshake.

## Interface
- INW, 12, data word width (matches MMM)
- M, 7, rows of A / output rows
- N, 9, columns of B / output columns
- MAXK, 8, maximum inner dimension; localparam K_BITS = $clog2(MAXK+1)
- TAGQ, 2, depth of owner-tag queue (maximum jobs in flight)
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- S0_TDATA / S1_TDATA  input  INW  requester data
- S0_TVALID / S1_TVALID  input  1  requester valid
- S0_TUSER / S1_TUSER  input  K_BITS+1  job header, sampled on the first beat of each job
- S0_TREADY / S1_TREADY  output  1  requester ready
- M_TDATA  output  INW  to MMM INPUT_TDATA
- M_TVALID  output  1  to MMM INPUT_TVALID
- M_TUSER  output  K_BITS+1  to MMM INPUT_TUSER
- M_TREADY  input  1  from MMM INPUT_TREADY
- RES_TVALID  input  1  snoop of MMM OUTPUT_TVALID
- RES_TREADY  input  1  snoop of MMM OUTPUT_TREADY
- RES_TID  output  1  owner of the current result word
- RES_TID_VALID  output  1  tag queue non-empty
- busy  output  1  state is PASS
- hdr_err  output  1  one-cycle pulse on a bad header

## Operation
**Job header (first beat of a job):**
- TUSER[K_BITS-1:0] = K.
- TUSER[K_BITS] = 1 means A-only (B reused). Job length L = M*K.
- TUSER[K_BITS] = 0 means L = M*K + K*N.
- K = 0 or K > MAXK: L = 1, hdr_err pulses.
- Beat counter width is $clog2(M*MAXK+MAXK*N+1).

**FSM states IDLE and PASS:**
- IDLE:
  - Candidates are the sources with TVALID=1.
  - Grant requires tag-queue count < TAGQ.
  - Winner is registered as owner; the owner is pushed to the tag queue.
  - Next state is PASS. No beat transfers in IDLE.
- PASS:
  - M_TDATA/M_TVALID/M_TUSER = owner's TDATA/TVALID/TUSER, combinational.
  - Owner TREADY = M_TREADY. The non-owner's TREADY = 0.
  - L is computed from the first beat.
  - The counter increments on each M_TVALID & M_TREADY.
  - On the handshake of beat L the FSM returns to IDLE.

**Arbitration:** round-robin. A register holds the last owner; the other source wins a tie. After reset the last owner is 1, so S0 wins the first tie.

**Tag queue (FIFO, depth TAGQ):**
- Head drives RES_TID.
- A result counter counts RES_TVALID & RES_TREADY. On count M*N it pops the head and clears.
- Simultaneous push and pop: count unchanged, both take effect.
- A result handshake with the queue empty is ignored; the counter does not advance.

**Reset values (reset = 0, asynchronous):**
- State = IDLE; queue empty; both counters = 0.
- All TREADY = 0, M_TVALID = 0, RES_TID_VALID = 0, busy = 0, hdr_err = 0, RES_TID = 0.
- Reset mid-job aborts the job. MMM shares the same reset.

## Timing
- Grant latency: valid seen in IDLE at cycle t; PASS at t+1; the first beat can transfer at t+1.
- Within a job: 1 beat/cycle when both sides are ready; zero added latency (combinational pass-through).
- Between jobs: exactly one IDLE bubble cycle.
- Tag pop is registered: RES_TID changes the cycle after the M*N-th result handshake.
- A requester deasserting TVALID mid-job stalls the job. The grant is held; there is no timeout.

## Configuration
- MMM_ARB_RR_EN defined: round-robin as described above.
- MMM_ARB_RR_EN undefined: fixed priority; S0 always wins a tie and the last-owner register is omitted. All other behaviour is identical.

## Test plan
- M=7, N=9, K=4, S0 only, full job: 64 beats forwarded in 64 cycles after a 1-cycle grant; busy high 64 cycles; 63 results tagged RES_TID=0.
- Both sources valid continuously, A-only jobs with K=4 (28 beats), RR enabled: grants alternate S0, S1, S0, S1; non-owner TREADY is never 1.
- Same stimulus, macro undefined: S0 is granted every job; S1 is starved.
- OUTPUT_TREADY held 0 with TAGQ=2: a third job is not granted until 63 results drain, then it is granted the cycle after the pop.
- Header K=0, then K=9 (MAXK=8): each is a 1-beat job with hdr_err pulsed once.
- reset driven 0 at beat 10 of a 64-beat job: all outputs go to reset values immediately; after release, a new S1 job is granted normally.
